wb_reg_writer: RTL and testbench

//  Write-side driver for the 32x32 register file's single write port (Awr/Din/WrEn).

---
 rtl/mips_pkg.sv | 15 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_reg_writer.sv | 101 ++++++++++
 tb/tb_wb_reg_writer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback entry type
// used by the write-port driver and its buffer.
package mips_pkg;

  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int REG_NUM = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with two ordered push ports
// (port a lands before port b) and a single pop port.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        push_a,
  input  wb_entry_t                   data_a,
  input  logic                        push_b,
  input  wb_entry_t                   data_b,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic [CW-1:0]               count,
  output wb_entry_t [DEPTH-1:0]       entries,
  output logic [DEPTH-1:0]            live
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   n_push;

  assign n_push = CW'(push_a) + CW'(push_b);

  // Storage carries no reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr_reg] <= data_a;
    if (push_b) mem[wr_ptr_reg + PW'(push_a)] <= data_b;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(n_push);
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + n_push - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst) assert (count_reg <= CW'(DEPTH));
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] offset;
    assign offset      = PW'(gi) - rd_ptr_reg;
    assign entries[gi] = mem[gi];
    assign live[gi]    = CW'(offset) < count_reg;
  end

endmodule

// File: rtl/wb_reg_writer.sv
// Register-file write-port driver: merges ALU and load writebacks in order,
// drains one write per cycle and exposes a per-register pending mask.
module wb_reg_writer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Alu_Valid,
  input  logic [AW-1:0]     Alu_Addr,
  input  logic [DW-1:0]     Alu_Data,
  output logic              Alu_Ready,
  input  logic              Mem_Valid,
  input  logic [AW-1:0]     Mem_Addr,
  input  logic [DW-1:0]     Mem_Data,
  output logic              Mem_Ready,
  output logic [AW-1:0]     Awr,
  output logic [DW-1:0]     Din,
  output logic              WrEn,
  output logic [REG_NUM-1:0] Pending,
  output logic              Busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]          count;
  logic [CW-1:0]          free;
  logic                   mem_nz;
  logic                   alu_nz;
  logic                   push_a;
  logic                   push_b;
  logic                   pop;
  wb_entry_t              head;
  wb_entry_t [DEPTH-1:0]  entries;
  logic [DEPTH-1:0]       live;

  logic                   wr_en_reg;
  logic [AW-1:0]          awr_reg;
  logic [DW-1:0]          din_reg;

  // Ready depends only on start-of-cycle occupancy, never on a same-cycle pop.
  assign free      = CW'(DEPTH) - count;
  assign mem_nz    = Mem_Addr != REG_ZERO;
  assign alu_nz    = Alu_Addr != REG_ZERO;
  assign Mem_Ready = free >= CW'(1);
  assign Alu_Ready = (free >= CW'(2)) || ((free == CW'(1)) && !(Mem_Valid && mem_nz));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign push_a = Mem_Valid && Mem_Ready && mem_nz;
  assign push_b = Alu_Valid && Alu_Ready && alu_nz;
  assign pop    = count != '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (Clk),
    .srst    (Rst),
    .push_a  (push_a),
    .data_a  ('{addr: Mem_Addr, data: Mem_Data}),
    .push_b  (push_b),
    .data_b  ('{addr: Alu_Addr, data: Alu_Data}),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .entries (entries),
    .live    (live)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_en_reg <= 1'b0;
      awr_reg   <= '0;
      din_reg   <= '0;
    end else begin
      wr_en_reg <= pop;
      if (pop) begin
        awr_reg <= head.addr;
        din_reg <= head.data;
      end
    end
  end

  assign WrEn = wr_en_reg;
  assign Awr  = awr_reg;
  assign Din  = din_reg;
  assign Busy = pop || wr_en_reg;

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_pend
    if (gi == 0) begin : g_zero
      assign Pending[gi] = 1'b0;
    end else begin : g_reg
      logic [DEPTH-1:0] hit;
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_hit
        assign hit[gj] = live[gj] && (entries[gj].addr == REG_AW'(gi));
      end
      assign Pending[gi] = (|hit) || (wr_en_reg && (awr_reg == AW'(gi)));
    end
  end

endmodule

// File: tb/tb_wb_reg_writer.sv
// Randomized scoreboard bench for wb_reg_writer against a queue-based model
// of the write buffer, write port and register file.
module tb_wb_reg_writer;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Alu_Valid = 1'b0;
  logic [4:0]  Alu_Addr = '0;
  logic [31:0] Alu_Data = '0;
  logic        Alu_Ready;
  logic        Mem_Valid = 1'b0;
  logic [4:0]  Mem_Addr = '0;
  logic [31:0] Mem_Data = '0;
  logic        Mem_Ready;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [31:0] Pending;
  logic        Busy;

  wb_reg_writer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .Alu_Valid(Alu_Valid), .Alu_Addr(Alu_Addr), .Alu_Data(Alu_Data), .Alu_Ready(Alu_Ready),
    .Mem_Valid(Mem_Valid), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data), .Mem_Ready(Mem_Ready),
    .Awr(Awr), .Din(Din), .WrEn(WrEn), .Pending(Pending), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  ent_t        exp_q[$];
  bit          port_v = 0;
  ent_t        port_e;
  bit          known = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf_dut [32] = '{default: 32'h0};
  logic [31:0] rf_exp [32] = '{default: 32'h0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Register file behind the write port.
  always @(posedge Clk) begin
    if (WrEn === 1'b1 && Awr != 5'd0) rf_dut[Awr] <= Din;
  end

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge Clk) begin
    if (known && WrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(Awr), 64'h100);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        $display("write r%0d = %h (expected r%0d = %h)", Awr, Din, e.a, e.d);
        chk("wr_addr", 64'(Awr), 64'(e.a));
        chk("wr_data", 64'(Din), 64'(e.d));
      end
    end
  end

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    if (port_v) p[port_e.a] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic cycle(input bit rst, input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
    int free;
    bit emr, ear;
    @(negedge Clk);
    Rst = rst;
    Mem_Valid = mv; Mem_Addr = ma; Mem_Data = md;
    Alu_Valid = av; Alu_Addr = aa; Alu_Data = ad;
    #1;
    free = DEPTH - mq.size();
    emr  = free >= 1;
    ear  = (free >= 2) || (free == 1 && !(mv && ma != 5'd0));
    if (known) begin
      chk("pending", 64'(Pending), 64'(exp_pending()));
      chk("busy", 64'(Busy), 64'((mq.size() != 0) || port_v));
      if (!rst) begin
        chk("mem_ready", 64'(Mem_Ready), 64'(emr));
        chk("alu_ready", 64'(Alu_Ready), 64'(ear));
      end
    end
    @(posedge Clk);
    if (port_v) rf_exp[port_e.a] = port_e.d;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      port_v = 0;
      known  = 1;
    end else begin
      port_v = mq.size() > 0;
      if (port_v) begin
        port_e = mq.pop_front();
        exp_q.push_back(port_e);
      end
      if (mv && emr && ma != 5'd0) mq.push_back('{a: ma, d: md});
      if (av && ear && aa != 5'd0) mq.push_back('{a: aa, d: ad});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  initial begin
    // Reset with both producers offering writes.
    cycle(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    cycle(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    #2;
    chk("rst_wren", 64'(WrEn), 64'h0);
    chk("rst_awr", 64'(Awr), 64'h0);
    chk("rst_din", 64'(Din), 64'h0);
    idle(3);
    chk("rst_no_write_r3", 64'(rf_dut[3]), 64'h0);

    // Single ALU write.
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF);
    idle(4);
    chk("reg5", 64'(rf_dut[5]), 64'hDEADBEEF);

    // Same-cycle Mem + ALU to the same register: ALU value lands last.
    cycle(0, 1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    idle(4);
    chk("reg3", 64'(rf_dut[3]), 64'h22);

    // Back-to-back dual accepts, then a single free slot with a load pending.
    cycle(0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hA1);
    cycle(0, 1, 5'd12, 32'hA2, 1, 5'd13, 32'hA3);
    cycle(0, 1, 5'd7,  32'hA4, 1, 5'd14, 32'hA5);
    cycle(0, 1, 5'd15, 32'hA6, 1, 5'd16, 32'hA7);
    idle(6);

    // ALU write to r0 is accepted and discarded.
    cycle(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF);
    idle(3);
    chk("reg0", 64'(rf_dut[0]), 64'h0);

    // Reset while entries are buffered.
    cycle(0, 1, 5'd20, 32'hB0, 1, 5'd21, 32'hB1);
    cycle(0, 1, 5'd22, 32'hB2, 1, 5'd23, 32'hB3);
    cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idle(4);

    // Randomized traffic with small address range for collisions.
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);

    chk("drained", 64'(exp_q.size()), 64'h0);
    for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), 64'(rf_dut[r]), 64'(rf_exp[r]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
